// File: rtl/calc_rpn.sv
// calc_rpn: stack-based (RPN) calculator between board switches/buttons and LEDs.
// Buttons are synchronised and edge-detected, so each press performs one action.
// Operands are pushed from sw onto a DEPTH-entry stack.
// Execute pops the top two entries, runs a DATA_W-bit ALU op and pushes the result.
// Optional build macro: CALC_SAT_EN. When defined, ADD/SUB saturate to signed limits.
// When it is undefined, ADD/SUB wrap modulo 2^DATA_W.
module calc_rpn #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btnc,
    input  logic                       btnd,
    input  logic                       btnu,
    input  logic                       btnl,
    input  logic                       btnr,
    input  logic [2:0]                 op_sel,
    input  logic [DATA_W-1:0]          sw,
    output logic [DATA_W-1:0]          led,
    output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
    output logic                       busy,
    output logic                       err,
    output logic                       zero
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DATA_W);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Bit positions in the button vectors; a lower index means lower priority.
    localparam int B_R = 0;
    localparam int B_L = 1;
    localparam int B_C = 2;
    localparam int B_D = 3;
    localparam int B_U = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

`ifdef CALC_SAT_EN
    // Clamp a (DATA_W+1)-bit signed sum or difference to the DATA_W signed range.
    // A differing top two bits means the true result left the range.
    function automatic logic [DATA_W-1:0] sat_w(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return s[DATA_W-1:0];
    endfunction
`endif

    function automatic logic [DATA_W-1:0] do_add(input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] y);
`ifdef CALC_SAT_EN
        logic signed [DATA_W:0] s;
        s = {x[DATA_W-1], x} + {y[DATA_W-1], y};
        return sat_w(s);
`else
        return x + y;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] do_sub(input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] y);
`ifdef CALC_SAT_EN
        logic signed [DATA_W:0] s;
        s = {x[DATA_W-1], x} - {y[DATA_W-1], y};
        return sat_w(s);
`else
        return x - y;
`endif
    endfunction

    // a is the older entry and b is the top entry.
    // Shifts use only the low log2(DATA_W) bits of b.
    function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [2:0]        op);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [SW-1:0]            sh;
        logic [DATA_W-1:0]        res;
        sa = a;
        sb = b;
        sh = b[SW-1:0];
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = do_add(sa, sb);
            OP_SUB:  res = do_sub(sa, sb);
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, (sa < sb)};
            OP_SLL:  res = a << sh;
            OP_SRA:  res = sa >>> sh;
            default: res = a ^ b;
        endcase
        return res;
    endfunction

    logic [4:0] btn_raw;
    logic [4:0] sync0_q;
    logic [4:0] sync1_q;
    logic [4:0] prev_q;
    logic [4:0] edge_w;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        op_q, op_d;

    logic [DATA_W-1:0] led_q, led_d;
    logic [CW-1:0]     depth_q;
    logic              zero_q, zero_d;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] stack_q [DEPTH];

    logic [AW-1:0]     cnt_idx;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     below_idx;
    logic [DATA_W-1:0] top_w;

    assign btn_raw = {btnu, btnd, btnc, btnl, btnr};
    assign edge_w  = sync1_q & ~prev_q;

    // Stack indices are derived from the count.
    // cnt_idx is only used when the stack is not full, so truncation is harmless.
    assign cnt_idx   = AW'(cnt_q);
    assign top_idx   = AW'(cnt_q - CW'(1));
    assign below_idx = AW'(cnt_q - CW'(2));
    assign top_w     = (cnt_q != '0) ? stack_q[top_idx] : '0;

    // Two-flop synchroniser plus previous-value flop per button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
        end else begin
            sync0_q <= btn_raw;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    // Next-state logic for the FSM, stack count, error flag and stack write port.
    // Edges are resolved by fixed priority in IDLE and dropped entirely in EXEC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        wr_en   = 1'b0;
        wr_addr = cnt_idx;
        wr_data = sw;
        case (state_q)
            IDLE: begin
                if (edge_w[B_U]) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                end else if (edge_w[B_D]) begin
                    if (cnt_q >= CW'(2)) begin
                        a_d     = stack_q[below_idx];
                        b_d     = stack_q[top_idx];
                        op_d    = op_sel;
                        state_d = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (edge_w[B_C]) begin
                    if (cnt_q == FULL) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = cnt_idx;
                        wr_data = sw;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else if (edge_w[B_L]) begin
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else if (edge_w[B_R]) begin
                    if ((cnt_q == '0) || (cnt_q == FULL)) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = cnt_idx;
                        wr_data = top_w;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            EXEC: begin
                wr_en   = 1'b1;
                wr_addr = below_idx;
                wr_data = alu(a_q, b_q, op_q);
                cnt_d   = cnt_q - CW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    // An asynchronous reset mid-EXEC returns the FSM to IDLE, so no write-back happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Operand and opcode latches for EXEC; these are pure data and are not reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_addr] <= wr_data;
        end
    end

    // The LED view of top-of-stack is zero when the stack is empty.
    always_comb begin
        led_d  = top_w;
        zero_d = (cnt_q != '0) && (top_w == '0);
    end

    // ---- output stage: registered view of the committed stack state ----
    // Output register: led, depth_cnt and zero lag the stack state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            depth_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            depth_q <= cnt_q;
            zero_q  <= zero_d;
        end
    end

    assign led       = led_q;
    assign depth_cnt = depth_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign busy      = (state_q == EXEC);

endmodule

// File: tb/tb_calc_rpn.sv
// Directed testbench for calc_rpn with DATA_W=16 and DEPTH=4.
// A table of two-operand ALU vectors drives the main checks.
// Hand-written sequences cover errors, held buttons, priority and reset during EXEC.
module tb_calc_rpn;

    localparam int DW = 16;
    localparam int DP = 4;

    localparam int B_R = 0;
    localparam int B_L = 1;
    localparam int B_C = 2;
    localparam int B_D = 3;
    localparam int B_U = 4;

    logic          clk;
    logic          rst;
    logic [4:0]    btn;
    logic [2:0]    op_sel;
    logic [DW-1:0] sw;
    logic [DW-1:0] led;
    logic [2:0]    depth_cnt;
    logic          busy;
    logic          err;
    logic          zero;

    int tests;
    int failures;
    int busy_cycles;

    calc_rpn #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnc      (btn[B_C]),
        .btnd      (btn[B_D]),
        .btnu      (btn[B_U]),
        .btnl      (btn[B_L]),
        .btnr      (btn[B_R]),
        .op_sel    (op_sel),
        .sw        (sw),
        .led       (led),
        .depth_cnt (depth_cnt),
        .busy      (busy),
        .err       (err),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        logic [DW-1:0] exp_led;
        logic          exp_zero;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold a button for 'hold' cycles, release it and let the pipeline settle.
    // The task counts the cycles in which busy was seen high.
    task automatic press(input int idx, input int hold);
        busy_cycles = 0;
        btn[idx] = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        btn[idx] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        sw = v;
        press(B_C, 1);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        btn      = '0;
        op_sel   = 3'b000;
        sw       = '0;

        vecs[0]  = '{16'h0005, 16'h0003, 3'b010, 16'h0008, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0004, 3'b110, 16'hF800, 1'b0};
        vecs[2]  = '{16'h0001, 16'h0004, 3'b101, 16'h0010, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 3'b100, 16'h0001, 1'b0};
        vecs[4]  = '{16'h00F0, 16'h0FF0, 3'b000, 16'h00F0, 1'b0};
        vecs[5]  = '{16'h0F00, 16'h00F0, 3'b001, 16'h0FF0, 1'b0};
        vecs[6]  = '{16'h0003, 16'h0005, 3'b011, 16'hFFFE, 1'b0};
        vecs[7]  = '{16'hAAAA, 16'hFFFF, 3'b111, 16'h5555, 1'b0};
        vecs[8]  = '{16'h0005, 16'h0005, 3'b011, 16'h0000, 1'b1};
        vecs[9]  = '{16'h0001, 16'hFFFF, 3'b100, 16'h0000, 1'b1};
        vecs[10] = '{16'h0001, 16'h0011, 3'b101, 16'h0002, 1'b0};
`ifdef CALC_SAT_EN
        vecs[11] = '{16'h7FFF, 16'h0001, 3'b010, 16'h7FFF, 1'b0};
        vecs[12] = '{16'h8000, 16'h8000, 3'b010, 16'h8000, 1'b0};
`else
        vecs[11] = '{16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0};
        vecs[12] = '{16'h8000, 16'h8000, 3'b010, 16'h0000, 1'b1};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_depth", 32'(depth_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);

        // Table-driven ALU vectors
        for (int i = 0; i < 13; i++) begin
            press(B_U, 1);
            push(vecs[i].a);
            push(vecs[i].b);
            op_sel = vecs[i].op;
            press(B_D, 1);
            check($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("v%0d_depth", i), 32'(depth_cnt), 32'h1);
            check($sformatf("v%0d_err", i), 32'(err), 32'h0);
            check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cycles), 32'h1);
        end

        // Overflow on push: led and depth are unchanged
        press(B_U, 1);
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        push(16'h0004);
        check("full_depth", 32'(depth_cnt), 32'h4);
        check("full_led", 32'(led), 32'h4);
        check("full_err", 32'(err), 32'h0);
        push(16'h0005);
        check("ovf_err", 32'(err), 32'h1);
        check("ovf_depth", 32'(depth_cnt), 32'h4);
        check("ovf_led", 32'(led), 32'h4);
        press(B_U, 1);
        check("clr_depth", 32'(depth_cnt), 32'h0);
        check("clr_err", 32'(err), 32'h0);
        check("clr_led", 32'(led), 32'h0);
        check("clr_zero", 32'(zero), 32'h0);

        // Dup and drop, then underflows on execute and drop
        push(16'h0007);
        press(B_R, 1);
        check("dup_depth", 32'(depth_cnt), 32'h2);
        check("dup_led", 32'(led), 32'h7);
        press(B_L, 1);
        check("drop_depth", 32'(depth_cnt), 32'h1);
        check("drop_err", 32'(err), 32'h0);
        op_sel = 3'b010;
        press(B_D, 1);
        check("exec1_err", 32'(err), 32'h1);
        check("exec1_depth", 32'(depth_cnt), 32'h1);
        check("exec1_led", 32'(led), 32'h7);
        check("exec1_busy_cycles", 32'(busy_cycles), 32'h0);
        press(B_L, 1);
        check("drop_last_depth", 32'(depth_cnt), 32'h0);
        check("drop_last_led", 32'(led), 32'h0);
        press(B_L, 1);
        check("udf_drop_err", 32'(err), 32'h1);
        check("udf_drop_depth", 32'(depth_cnt), 32'h0);
        press(B_U, 1);
        press(B_R, 1);
        check("udf_dup_err", 32'(err), 32'h1);
        check("udf_dup_depth", 32'(depth_cnt), 32'h0);

        // Dup on a full stack is an overflow
        press(B_U, 1);
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        push(16'h0044);
        press(B_R, 1);
        check("ovf_dup_err", 32'(err), 32'h1);
        check("ovf_dup_depth", 32'(depth_cnt), 32'h4);
        check("ovf_dup_led", 32'(led), 32'h44);

        // A button held for 100 cycles gives exactly one push
        press(B_U, 1);
        sw = 16'h1234;
        press(B_C, 100);
        check("hold_depth", 32'(depth_cnt), 32'h1);
        check("hold_led", 32'(led), 32'h1234);

        // btnu and btnc in the same cycle: only the clear happens
        btn = 5'b10100;
        @(negedge clk);
        btn = '0;
        repeat (8) @(negedge clk);
        check("prio_depth", 32'(depth_cnt), 32'h0);
        check("prio_err", 32'(err), 32'h0);
        check("prio_led", 32'(led), 32'h0);

        // A btnc edge that lands in the EXEC cycle is dropped
        push(16'h0009);
        push(16'h0006);
        op_sel = 3'b011;
        sw = 16'h5555;
        btn[B_D] = 1'b1;
        @(negedge clk);
        btn[B_C] = 1'b1;
        @(negedge clk);
        btn = '0;
        repeat (8) @(negedge clk);
        check("exec_drop_depth", 32'(depth_cnt), 32'h1);
        check("exec_drop_led", 32'(led), 32'h3);

        // Reset asserted during EXEC clears every output immediately
        push(16'h0002);
        op_sel = 3'b010;
        btn[B_D] = 1'b1;
        begin
            int waited;
            waited = 0;
            while (!busy && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check("exec_busy_seen", 32'(busy), 32'h1);
        end
        rst = 1'b1;
        #1;
        check("rst_exec_led", 32'(led), 32'h0);
        check("rst_exec_depth", 32'(depth_cnt), 32'h0);
        check("rst_exec_busy", 32'(busy), 32'h0);
        check("rst_exec_err", 32'(err), 32'h0);
        check("rst_exec_zero", 32'(zero), 32'h0);
        btn = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_depth", 32'(depth_cnt), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        push(16'h00AB);
        check("post_rst_push_led", 32'(led), 32'hAB);
        check("post_rst_push_depth", 32'(depth_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
